// File: rtl/id_control_stage_if.sv
// Handshake and decoded-field bundle between the IF/ID register, the decode stage and EX.
interface id_control_stage_if #(
  parameter int INSTR_W      = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int CONTROL_SIZE = 20,
  parameter int STALL_CNT_W  = 16
);
  logic [INSTR_W-1:0]      i_instr;
  logic                    i_valid;
  logic                    o_ready;
  logic                    i_ex_ready;
  logic                    i_flush;
  logic [CONTROL_SIZE-1:0] o_control;
  logic [REG_ADDR_W-1:0]   o_rs;
  logic [REG_ADDR_W-1:0]   o_rt;
  logic [REG_ADDR_W-1:0]   o_rd;
  logic [15:0]             o_imm;
  logic                    o_valid;
  logic                    o_bubble;
  logic                    o_halted;
  logic                    o_illegal;
  logic [STALL_CNT_W-1:0]  o_stall_count;

  modport master (
    output i_instr, i_valid, i_ex_ready, i_flush,
    input  o_ready, o_control, o_rs, o_rt, o_rd, o_imm,
           o_valid, o_bubble, o_halted, o_illegal, o_stall_count
  );

  modport slave (
    input  i_instr, i_valid, i_ex_ready, i_flush,
    output o_ready, o_control, o_rs, o_rt, o_rd, o_imm,
           o_valid, o_bubble, o_halted, o_illegal, o_stall_count
  );
endinterface

// File: rtl/id_control_stage.sv
// Registered MIPS decode stage: one instruction per cycle, 1-cycle latency, valid/ready toward EX.
// Optional load-use bubble insertion is enabled by defining LOAD_USE_STALL_EN.
module id_control_stage #(
  parameter int INSTR_W      = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int CONTROL_SIZE = 20,
  parameter int STALL_CNT_W  = 16
) (
  input logic          i_clk,
  input logic          i_rst_n,
  id_control_stage_if.slave bus
);

  localparam int C_REG_WRITE = 0;
  localparam int C_BRANCH    = 1;
  localparam int C_UNSIGNED  = 2;
  localparam int C_MEM_READ  = 3;
  localparam int C_MEM_WRITE = 4;
  localparam int C_REG_DST   = 7;
  localparam int C_SRC_A     = 8;
  localparam int C_SRC_B     = 9;
  localparam int C_MEM_2_REG = 13;
  localparam int C_J_RET_DST = 14;
  localparam int C_EQ_OR_NE  = 15;
  localparam int C_JUMP_SRC  = 16;
  localparam int C_JUMP_OR_B = 17;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t state_q, state_d;
  logic   run;

  logic [5:0]            op;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] in_rs;
  logic [REG_ADDR_W-1:0] in_rt;
  logic [REG_ADDR_W-1:0] in_rd;

  logic [19:0] dec_ctrl;
  logic        dec_illegal;
  logic        dec_halt;

  logic                  valid_q;
  logic [19:0]           ctrl_q;
  logic [REG_ADDR_W-1:0] rs_q;
  logic [REG_ADDR_W-1:0] rt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [15:0]           imm_q;
  logic                  illegal_q;

  logic advance;
  logic hazard;
  logic ready;
  logic accept;
  logic bubble_load;

  assign op    = bus.i_instr[31:26];
  assign funct = bus.i_instr[5:0];
  assign in_rs = REG_ADDR_W'(bus.i_instr[25:21]);
  assign in_rt = REG_ADDR_W'(bus.i_instr[20:16]);
  assign in_rd = REG_ADDR_W'(bus.i_instr[15:11]);

  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    dec_halt    = 1'b0;
    case (op)
      6'b000000: begin
        dec_ctrl[C_REG_WRITE] = 1'b1;
        dec_ctrl[C_REG_DST]   = 1'b1;
        dec_ctrl[12:10]       = ALU_RTYPE;
        case (funct)
          6'b000000, 6'b000010, 6'b000011: dec_ctrl[C_SRC_A] = 1'b1;
          6'b100001, 6'b100011, 6'b101011: dec_ctrl[C_UNSIGNED] = 1'b1;
          6'b000100, 6'b000110, 6'b000111,
          6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010: begin
          end
          6'b001000: begin
            dec_ctrl              = '0;
            dec_ctrl[C_JUMP_OR_B] = 1'b1;
          end
          6'b001001: begin
            dec_ctrl              = '0;
            dec_ctrl[C_JUMP_OR_B] = 1'b1;
            dec_ctrl[C_REG_WRITE] = 1'b1;
            dec_ctrl[C_REG_DST]   = 1'b1;
            dec_ctrl[C_J_RET_DST] = 1'b1;
          end
          default: begin
            dec_ctrl    = '0;
            dec_illegal = 1'b1;
          end
        endcase
      end
      // Loads: op[1:0] encodes the access size, op[2] the zero-extending variants.
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100111: begin
        dec_ctrl[C_REG_WRITE] = 1'b1;
        dec_ctrl[C_MEM_READ]  = 1'b1;
        dec_ctrl[C_MEM_2_REG] = 1'b1;
        dec_ctrl[C_SRC_B]     = 1'b1;
        dec_ctrl[12:10]       = ALU_ADD;
        dec_ctrl[C_UNSIGNED]  = op[2];
        case (op[1:0])
          2'b00:   dec_ctrl[19:18] = SZ_BYTE;
          2'b01:   dec_ctrl[19:18] = SZ_HALF;
          default: dec_ctrl[19:18] = SZ_WORD;
        endcase
      end
      6'b101000, 6'b101001, 6'b101011: begin
        dec_ctrl[C_MEM_WRITE] = 1'b1;
        dec_ctrl[C_SRC_B]     = 1'b1;
        dec_ctrl[12:10]       = ALU_ADD;
        case (op[1:0])
          2'b00:   dec_ctrl[19:18] = SZ_BYTE;
          2'b01:   dec_ctrl[19:18] = SZ_HALF;
          default: dec_ctrl[19:18] = SZ_WORD;
        endcase
      end
      6'b001000, 6'b001001: begin
        dec_ctrl[C_REG_WRITE] = 1'b1;
        dec_ctrl[C_SRC_B]     = 1'b1;
        dec_ctrl[12:10]       = ALU_ADD;
        dec_ctrl[C_UNSIGNED]  = op[0];
      end
      6'b001010, 6'b001011: begin
        dec_ctrl[C_REG_WRITE] = 1'b1;
        dec_ctrl[C_SRC_B]     = 1'b1;
        dec_ctrl[12:10]       = ALU_SLT;
        dec_ctrl[C_UNSIGNED]  = op[0];
      end
      6'b001100, 6'b001101, 6'b001110: begin
        dec_ctrl[C_REG_WRITE] = 1'b1;
        dec_ctrl[C_SRC_B]     = 1'b1;
        dec_ctrl[C_UNSIGNED]  = 1'b1;
        case (op[1:0])
          2'b00:   dec_ctrl[12:10] = ALU_AND;
          2'b01:   dec_ctrl[12:10] = ALU_OR;
          default: dec_ctrl[12:10] = ALU_XOR;
        endcase
      end
      6'b001111: begin
        dec_ctrl[C_REG_WRITE] = 1'b1;
        dec_ctrl[C_SRC_B]     = 1'b1;
        dec_ctrl[12:10]       = ALU_LUI;
      end
      6'b000100, 6'b000101: begin
        dec_ctrl[C_BRANCH]   = 1'b1;
        dec_ctrl[C_EQ_OR_NE] = ~op[0];
        dec_ctrl[12:10]      = ALU_SUB;
      end
      6'b000010, 6'b000011: begin
        dec_ctrl[C_JUMP_OR_B] = 1'b1;
        dec_ctrl[C_JUMP_SRC]  = 1'b1;
        dec_ctrl[C_REG_WRITE] = op[0];
        dec_ctrl[C_J_RET_DST] = op[0];
      end
      6'b111111: dec_halt = 1'b1;
      default:   dec_illegal = 1'b1;
    endcase
  end

  assign advance = !valid_q || bus.i_ex_ready;

`ifdef LOAD_USE_STALL_EN
  assign hazard = valid_q && ctrl_q[C_MEM_READ] && (rt_q != '0) &&
                  ((rt_q == in_rs) || (rt_q == in_rt));
`else
  assign hazard = 1'b0;
`endif

  assign ready       = run && advance && !hazard && !bus.i_flush;
  assign accept      = ready && bus.i_valid;
  assign bubble_load = run && bus.i_valid && advance && hazard && !bus.i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // HALT is only left through reset; a flushed HALT never reaches accept.
  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      S_RUN: begin
        run = 1'b1;
        if (accept && dec_halt) state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
    end else if (bus.i_flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
    end else if (advance) begin
      if (accept) begin
        valid_q <= 1'b1;
        ctrl_q  <= dec_ctrl;
        rs_q    <= in_rs;
        rt_q    <= in_rt;
        rd_q    <= in_rd;
        imm_q   <= bus.i_instr[15:0];
      end else begin
        valid_q <= bubble_load;
        ctrl_q  <= '0;
        rs_q    <= '0;
        rt_q    <= '0;
        rd_q    <= '0;
        imm_q   <= '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      illegal_q <= 1'b0;
    end else if (accept && dec_illegal) begin
      illegal_q <= 1'b1;
    end
  end

`ifdef LOAD_USE_STALL_EN
  logic                   bubble_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bubble_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.i_flush) begin
        bubble_q <= 1'b0;
      end else if (advance) begin
        bubble_q <= bubble_load;
      end
      if (bubble_load && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign bus.o_bubble      = bubble_q;
  assign bus.o_stall_count = stall_cnt_q;
`else
  assign bus.o_bubble      = 1'b0;
  assign bus.o_stall_count = '0;
`endif

  assign bus.o_ready   = ready;
  assign bus.o_valid   = valid_q;
  assign bus.o_control = CONTROL_SIZE'(ctrl_q);
  assign bus.o_rs      = rs_q;
  assign bus.o_rt      = rt_q;
  assign bus.o_rd      = rd_q;
  assign bus.o_imm     = imm_q;
  assign bus.o_halted  = (state_q == S_HALT);
  assign bus.o_illegal = illegal_q;

endmodule

// File: tb/tb_id_control_stage.sv
// Directed bench for id_control_stage: decode table plus hazard, stall, flush, illegal, halt and reset sequences.
module tb_id_control_stage;

  typedef struct {
    logic [31:0] instr;
    logic [19:0] ctrl;
    string       name;
  } vec_t;

`ifdef LOAD_USE_STALL_EN
  localparam logic [31:0] EXP_STALL = 32'd1;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic i_clk;
  logic i_rst_n;
  int   n_checks;
  int   n_errors;
  vec_t tbl[$];

  id_control_stage_if intf ();

  id_control_stage dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (intf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] rty(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] ity(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic addv(input logic [31:0] ins, input logic [19:0] c, input string n);
    vec_t v;
    v.instr = ins;
    v.ctrl  = c;
    v.name  = n;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic drive(input logic vld, input logic [31:0] ins);
    intf.i_valid = vld;
    intf.i_instr = ins;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    addv(rty(5'd1, 5'd2, 5'd3, 6'h21), 20'h01C85, "addu");
    addv(rty(5'd1, 5'd2, 5'd3, 6'h23), 20'h01C85, "subu");
    addv(rty(5'd1, 5'd2, 5'd3, 6'h2B), 20'h01C85, "sltu");
    addv(rty(5'd1, 5'd2, 5'd3, 6'h24), 20'h01C81, "and");
    addv(rty(5'd1, 5'd2, 5'd3, 6'h2A), 20'h01C81, "slt");
    addv(rty(5'd1, 5'd2, 5'd3, 6'h00), 20'h01D81, "sll");
    addv(rty(5'd1, 5'd2, 5'd3, 6'h03), 20'h01D81, "sra");
    addv(rty(5'd1, 5'd2, 5'd3, 6'h04), 20'h01C81, "sllv");
    addv(rty(5'd1, 5'd0, 5'd0, 6'h08), 20'h20000, "jr");
    addv(rty(5'd1, 5'd0, 5'd31, 6'h09), 20'h24081, "jalr");
    addv(ity(6'h20, 5'd1, 5'd9, 16'd0), 20'h02209, "lb");
    addv(ity(6'h21, 5'd1, 5'd10, 16'd2), 20'h42209, "lh");
    addv(ity(6'h23, 5'd1, 5'd11, 16'd4), 20'hC2209, "lw");
    addv(ity(6'h24, 5'd1, 5'd12, 16'd0), 20'h0220D, "lbu");
    addv(ity(6'h25, 5'd1, 5'd13, 16'd2), 20'h4220D, "lhu");
    addv(ity(6'h27, 5'd1, 5'd14, 16'd4), 20'hC220D, "lwu");
    addv(ity(6'h28, 5'd1, 5'd2, 16'd0), 20'h00210, "sb");
    addv(ity(6'h29, 5'd1, 5'd2, 16'd2), 20'h40210, "sh");
    addv(ity(6'h2B, 5'd1, 5'd2, 16'd4), 20'hC0210, "sw");
    addv(ity(6'h08, 5'd1, 5'd2, 16'd5), 20'h00201, "addi");
    addv(ity(6'h09, 5'd1, 5'd2, 16'd5), 20'h00205, "addiu");
    addv(ity(6'h0A, 5'd1, 5'd2, 16'd5), 20'h01A01, "slti");
    addv(ity(6'h0B, 5'd1, 5'd2, 16'd5), 20'h01A05, "sltiu");
    addv(ity(6'h0C, 5'd1, 5'd2, 16'd5), 20'h00A05, "andi");
    addv(ity(6'h0D, 5'd1, 5'd2, 16'd5), 20'h00E05, "ori");
    addv(ity(6'h0E, 5'd1, 5'd2, 16'd5), 20'h01205, "xori");
    addv(ity(6'h0F, 5'd0, 5'd2, 16'd5), 20'h01601, "lui");
    addv(ity(6'h04, 5'd1, 5'd2, 16'd8), 20'h08402, "beq");
    addv(ity(6'h05, 5'd1, 5'd2, 16'd8), 20'h00402, "bne");
    addv(32'h0800_0010, 20'h30000, "j");
    addv(32'h0C00_0010, 20'h34001, "jal");

    // Reset state
    i_rst_n = 1'b0;
    intf.i_instr = '0;
    intf.i_valid = 1'b0;
    intf.i_ex_ready = 1'b1;
    intf.i_flush = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(intf.o_valid), 32'd0);
    chk("rst_control", 32'(intf.o_control), 32'd0);
    chk("rst_halted", 32'(intf.o_halted), 32'd0);
    chk("rst_illegal", 32'(intf.o_illegal), 32'd0);
    chk("rst_stall", 32'(intf.o_stall_count), 32'd0);
    i_rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(intf.o_ready), 32'd1);

    // ADDU $3,$1,$2 with field check
    drive(1'b1, 32'h0022_1821);
    step();
    drive(1'b0, 32'h0);
    chk("addu_valid", 32'(intf.o_valid), 32'd1);
    chk("addu_ctrl", 32'(intf.o_control), 32'h01C85);
    chk("addu_rs", 32'(intf.o_rs), 32'd1);
    chk("addu_rt", 32'(intf.o_rt), 32'd2);
    chk("addu_rd", 32'(intf.o_rd), 32'd3);
    chk("addu_imm", 32'(intf.o_imm), 32'h1821);
    step();
    chk("drain_valid", 32'(intf.o_valid), 32'd0);

    // Back-to-back decode table
    for (int i = 0; i < tbl.size(); i++) begin
      drive(1'b1, tbl[i].instr);
      #1;
      chk({"ready_", tbl[i].name}, 32'(intf.o_ready), 32'd1);
      step();
      chk({"ctrl_", tbl[i].name}, 32'(intf.o_control), 32'(tbl[i].ctrl));
      chk({"valid_", tbl[i].name}, 32'(intf.o_valid), 32'd1);
    end
    drive(1'b0, 32'h0);
    step();

    // Load-use: LW $2,0($1) then ADDU $3,$2,$4
    drive(1'b1, ity(6'h23, 5'd1, 5'd2, 16'd0));
    step();
    chk("lu_lw_ctrl", 32'(intf.o_control), 32'hC2209);
    drive(1'b1, rty(5'd2, 5'd4, 5'd3, 6'h21));
    #1;
`ifdef LOAD_USE_STALL_EN
    chk("lu_ready", 32'(intf.o_ready), 32'd0);
    step();
    chk("lu_bubble", 32'(intf.o_bubble), 32'd1);
    chk("lu_bub_valid", 32'(intf.o_valid), 32'd1);
    chk("lu_bub_ctrl", 32'(intf.o_control), 32'd0);
`else
    chk("lu_ready", 32'(intf.o_ready), 32'd1);
`endif
    step();
    chk("lu_addu_ctrl", 32'(intf.o_control), 32'h01C85);
    chk("lu_addu_bubble", 32'(intf.o_bubble), 32'd0);
    chk("lu_stall", 32'(intf.o_stall_count), EXP_STALL);
    drive(1'b0, 32'h0);

    // Hazard together with flush: no bubble, counter unchanged
    drive(1'b1, ity(6'h23, 5'd1, 5'd2, 16'd0));
    step();
    drive(1'b1, rty(5'd2, 5'd4, 5'd3, 6'h21));
    intf.i_flush = 1'b1;
    step();
    intf.i_flush = 1'b0;
    drive(1'b0, 32'h0);
    chk("hf_valid", 32'(intf.o_valid), 32'd0);
    chk("hf_bubble", 32'(intf.o_bubble), 32'd0);
    chk("hf_stall", 32'(intf.o_stall_count), EXP_STALL);

    // EX backpressure holds SW for 3 cycles
    drive(1'b1, ity(6'h2B, 5'd1, 5'd2, 16'd4));
    step();
    intf.i_ex_ready = 1'b0;
    drive(1'b1, ity(6'h0D, 5'd1, 5'd2, 16'h0005));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_ctrl", 32'(intf.o_control), 32'hC0210);
      chk("bp_ready", 32'(intf.o_ready), 32'd0);
    end
    intf.i_ex_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(intf.o_ready), 32'd1);
    step();
    drive(1'b0, 32'h0);
    chk("bp_ori_ctrl", 32'(intf.o_control), 32'h00E05);

    // Flush with BEQ in output and J on input
    drive(1'b1, ity(6'h04, 5'd1, 5'd2, 16'd8));
    step();
    chk("fl_beq_ctrl", 32'(intf.o_control), 32'h08402);
    drive(1'b1, 32'h0800_0010);
    intf.i_flush = 1'b1;
    #1;
    chk("fl_ready", 32'(intf.o_ready), 32'd0);
    step();
    intf.i_flush = 1'b0;
    drive(1'b0, 32'h0);
    chk("fl_valid", 32'(intf.o_valid), 32'd0);
    chk("fl_ctrl", 32'(intf.o_control), 32'd0);
    #1;
    chk("fl_ready_after", 32'(intf.o_ready), 32'd1);

    // Flushed HALT is ignored
    drive(1'b1, 32'hFC00_0000);
    intf.i_flush = 1'b1;
    step();
    intf.i_flush = 1'b0;
    drive(1'b0, 32'h0);
    chk("flhalt_halted", 32'(intf.o_halted), 32'd0);
    chk("flhalt_valid", 32'(intf.o_valid), 32'd0);

    // Illegal opcode is sticky; following ORI still decodes
    drive(1'b1, ity(6'h3E, 5'd0, 5'd0, 16'd0));
    step();
    chk("ill_flag", 32'(intf.o_illegal), 32'd1);
    chk("ill_valid", 32'(intf.o_valid), 32'd1);
    chk("ill_ctrl", 32'(intf.o_control), 32'd0);
    drive(1'b1, ity(6'h0D, 5'd1, 5'd2, 16'h00FF));
    step();
    drive(1'b0, 32'h0);
    chk("ill_ori_ctrl", 32'(intf.o_control), 32'h00E05);
    chk("ill_ori_imm", 32'(intf.o_imm), 32'h00FF);
    chk("ill_sticky", 32'(intf.o_illegal), 32'd1);

    // HALT: stops accepting, output drains
    drive(1'b1, 32'hFC00_0000);
    step();
    chk("halt_flag", 32'(intf.o_halted), 32'd1);
    chk("halt_valid", 32'(intf.o_valid), 32'd1);
    chk("halt_ctrl", 32'(intf.o_control), 32'd0);
    chk("halt_ready", 32'(intf.o_ready), 32'd0);
    drive(1'b1, 32'h0022_1821);
    step();
    chk("halt_drain_valid", 32'(intf.o_valid), 32'd0);
    chk("halt_ready2", 32'(intf.o_ready), 32'd0);
    step();
    chk("halt_no_accept", 32'(intf.o_valid), 32'd0);
    chk("halt_stays", 32'(intf.o_halted), 32'd1);

    // Reset mid-operation clears immediately
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mrst_halted", 32'(intf.o_halted), 32'd0);
    chk("mrst_illegal", 32'(intf.o_illegal), 32'd0);
    chk("mrst_stall", 32'(intf.o_stall_count), 32'd0);
    chk("mrst_valid", 32'(intf.o_valid), 32'd0);
    step();
    i_rst_n = 1'b1;
    #1;
    chk("mrst_ready", 32'(intf.o_ready), 32'd1);
    step();
    drive(1'b0, 32'h0);
    chk("mrst_addu_ctrl", 32'(intf.o_control), 32'h01C85);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
